// File: rtl/snn_proc_pkg.sv
// rtl/snn_proc_pkg.sv - shared opcodes, field positions and FSM states for axis_snn_processor
package snn_proc_pkg;

  localparam int DATA_W_DEFAULT     = 8;
  localparam int NUM_INP            = 2;
  localparam int OUT_THRESH_DEFAULT = 2;
  localparam int RUN_W              = 6;
  localparam int POT_W              = 4;

  localparam int OPC_HI      = 7;
  localparam int OPC_LO      = 6;
  localparam int AS_IDX_BIT  = 5;
  localparam int AS_TIME_BIT = 4;
  localparam int AS_VAL_BIT  = 3;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_RUN = 2'b01,
    OP_AS  = 2'b10,
    OP_CLR = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_STEP = 2'b01,
    S_EMIT = 2'b10
  } state_t;

endpackage

// File: rtl/snn_core.sv
// rtl/snn_core.sv - spike schedule, neuron state and single-timestep update
module snn_core
  import snn_proc_pkg::*;
#(
  parameter int OUT_THRESH = OUT_THRESH_DEFAULT
) (
  input  logic       clk,
  input  logic       arstn,
  input  logic       clr,
  input  logic       as_en,
  input  logic       as_idx,
  input  logic       as_time,
  input  logic       as_val,
  input  logic       step_en,
  output logic [2:0] spikes
);

  logic [NUM_INP-1:0] slot0_q, slot0_d;
  logic [NUM_INP-1:0] slot1_q, slot1_d;
  logic [NUM_INP-1:0] fire_dly_q, fire_dly_d;
  logic [POT_W-1:0]   pot_q, pot_d;
  logic [POT_W-1:0]   pot_sum;
  logic               n2_fire;

  // spikes always reflects the step that would execute now; the top samples it on step_en
  always_comb begin
    pot_sum    = pot_q + POT_W'(fire_dly_q[0]) + POT_W'(fire_dly_q[1]);
    n2_fire    = (pot_sum >= POT_W'(OUT_THRESH));
    spikes     = {n2_fire, slot0_q};
    slot0_d    = slot0_q;
    slot1_d    = slot1_q;
    fire_dly_d = fire_dly_q;
    pot_d      = pot_q;
    if (clr) begin
      slot0_d    = '0;
      slot1_d    = '0;
      fire_dly_d = '0;
      pot_d      = '0;
    end else if (step_en) begin
      slot0_d    = slot1_q;
      slot1_d    = '0;
      fire_dly_d = slot0_q;
      pot_d      = n2_fire ? '0 : pot_sum;
    end else if (as_en && as_val) begin
      if (as_time) slot1_d[as_idx] = 1'b1;
      else         slot0_d[as_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      slot0_q    <= '0;
      slot1_q    <= '0;
      fire_dly_q <= '0;
      pot_q      <= '0;
    end else begin
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      fire_dly_q <= fire_dly_d;
      pot_q      <= pot_d;
    end
  end

endmodule

// File: rtl/axis_snn_processor.sv
// rtl/axis_snn_processor.sv - AXI-Stream command decoder and step sequencer around snn_core
module axis_snn_processor
  import snn_proc_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int OUT_THRESH = OUT_THRESH_DEFAULT
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready
);

  state_t            state_q, state_d;
  logic [RUN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tready_q, tready_d;

  opcode_t           opc;
  logic [RUN_W-1:0]  run_n;
  logic              cmd_acc;
  logic              core_clr;
  logic              core_as_en;
  logic              step_en;
  logic [2:0]        spikes;

  assign opc           = opcode_t'(s_axis_tdata[OPC_HI:OPC_LO]);
  assign run_n         = s_axis_tdata[RUN_W-1:0];
  assign s_axis_tready = tready_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;

  // tready is registered so it stays low through the reset edge and rises one cycle later
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tready_d   = tready_q;
    step_en    = 1'b0;
    cmd_acc    = s_axis_tvalid && tready_q;
    core_clr   = cmd_acc && (opc == OP_CLR);
    core_as_en = cmd_acc && (opc == OP_AS);
    case (state_q)
      S_IDLE: begin
        tready_d = 1'b1;
        if (cmd_acc && (opc == OP_RUN) && (run_n != '0)) begin
          cnt_d    = run_n;
          state_d  = S_STEP;
          tready_d = 1'b0;
        end
      end
      S_STEP: begin
        step_en  = 1'b1;
        tdata_d  = {{(DATA_W-3){1'b0}}, spikes};
        tvalid_d = 1'b1;
        state_d  = S_EMIT;
      end
      S_EMIT: begin
        if (m_axis_tready) begin
          tvalid_d = 1'b0;
          cnt_d    = cnt_q - RUN_W'(1);
          if (cnt_d != '0) begin
            state_d = S_STEP;
          end else begin
            state_d  = S_IDLE;
            tready_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        tvalid_d = 1'b0;
        tready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tready_q <= tready_d;
    end
  end

  snn_core #(
    .OUT_THRESH(OUT_THRESH)
  ) u_core (
    .clk     (clk),
    .arstn   (arstn),
    .clr     (core_clr),
    .as_en   (core_as_en),
    .as_idx  (s_axis_tdata[AS_IDX_BIT]),
    .as_time (s_axis_tdata[AS_TIME_BIT]),
    .as_val  (s_axis_tdata[AS_VAL_BIT]),
    .step_en (step_en),
    .spikes  (spikes)
  );

endmodule

// File: tb/tb_axis_snn_processor.sv
// tb/tb_axis_snn_processor.sv - scoreboard bench for axis_snn_processor
module tb_axis_snn_processor;

  localparam int THRESH = 2;

  logic       clk = 1'b0;
  logic       arstn = 1'b0;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;

  int checks = 0;
  int failures = 0;
  int pushed_total = 0;
  int rx_total = 0;

  logic [7:0] expq[$];
  bit         sched[2][2];
  bit         dly[2];
  int         pot;

  bit         rand_bp = 0;
  bit         bp_force_low = 0;
  bit         hold_valid = 0;
  logic [7:0] hold_data = 8'h00;

  axis_snn_processor #(.DATA_W(8), .OUT_THRESH(THRESH)) dut (
    .clk           (clk),
    .arstn         (arstn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 2; i++) begin
      sched[i][0] = 0;
      sched[i][1] = 0;
      dly[i] = 0;
    end
    pot = 0;
  endfunction

  // Network behaviour expressed per input as a two-entry future-spike list
  function automatic void model_apply(input logic [7:0] b);
    bit f0, f1, f2;
    case (b[7:6])
      2'b11: model_clear();
      2'b10: if (b[3]) sched[b[5]][b[4]] = 1;
      2'b01: begin
        for (int s = 0; s < int'(b[5:0]); s++) begin
          f0 = sched[0][0];
          f1 = sched[1][0];
          pot = pot + int'(dly[0]) + int'(dly[1]);
          f2 = (pot >= THRESH);
          if (f2) pot = 0;
          expq.push_back({5'b0, f2, f1, f0});
          pushed_total++;
          dly[0] = f0;
          dly[1] = f1;
          for (int i = 0; i < 2; i++) begin
            sched[i][0] = sched[i][1];
            sched[i][1] = 0;
          end
        end
      end
      default: ;
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    if (bp_force_low) m_axis_tready = 1'b0;
    else if (rand_bp) m_axis_tready = 1'($urandom_range(0, 1));
    else m_axis_tready = 1'b1;
  end

  always @(negedge clk) begin
    if (arstn && m_axis_tvalid) begin
      if (s_axis_tready) begin
        checks++;
        failures++;
        $display("FAIL s_tready_during_output actual=1 expected=0");
      end
      if (hold_valid && (m_axis_tdata != hold_data)) begin
        checks++;
        failures++;
        $display("FAIL tdata_stable actual=%0h expected=%0h", m_axis_tdata, hold_data);
      end
      if (m_axis_tready) begin
        rx_total++;
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_packet actual=%0h expected=none", m_axis_tdata);
        end else begin
          check("packet", int'(m_axis_tdata), int'(expq.pop_front()));
        end
        hold_valid = 0;
      end else begin
        hold_valid = 1;
        hold_data  = m_axis_tdata;
      end
    end else begin
      hold_valid = 0;
    end
  end

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (!s_axis_tready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      check("send_timeout", 1, 0);
    end else begin
      s_axis_tdata  = b;
      s_axis_tvalid = 1'b1;
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 8'($urandom);
      model_apply(b);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((expq.size() != 0 || !s_axis_tready) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 4000) check("drain_timeout", expq.size(), 0);
  endtask

  initial begin
    logic [7:0] cmd;
    int t;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", int'(s_axis_tready), 0);
    check("rst_m_tvalid", int'(m_axis_tvalid), 0);
    check("rst_m_tdata", int'(m_axis_tdata), 0);
    arstn = 1'b1;
    @(negedge clk);
    check("rst_s_tready_low_before_edge", int'(s_axis_tready), 0);
    @(posedge clk);
    #1;
    check("s_tready_after_release", int'(s_axis_tready), 1);

    send(8'hC0); send(8'h88); send(8'h43); drain();
    send(8'hA8); send(8'h43); drain();
    send(8'h88); send(8'hA8); send(8'h43); drain();
    check("directed_packet_count", rx_total, 9);

    send(8'h98); send(8'h42); drain();
    send(8'h40);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("run0_s_tready", int'(s_axis_tready), 1);
      check("run0_m_tvalid", int'(m_axis_tvalid), 0);
    end

    rand_bp = 1;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0:       cmd = {2'b11, 6'($urandom)};
        1:       cmd = {2'b00, 6'($urandom)};
        2, 3, 4, 5: cmd = {2'b10, 6'($urandom)};
        default: cmd = {2'b01, 6'($urandom_range(0, 4))};
      endcase
      send(cmd);
    end
    drain();
    rand_bp = 0;

    send(8'h88); send(8'hA8); send(8'h43);
    t = 0;
    while (!m_axis_tvalid && t < 100) begin @(negedge clk); t++; end
    bp_force_low = 1;
    repeat (6) @(posedge clk);
    #2;
    check("stall_s_tready", int'(s_axis_tready), 0);
    check("stall_m_tvalid", int'(m_axis_tvalid), 1);
    bp_force_low = 0;
    drain();

    send(8'h88); send(8'h48);
    t = 0;
    while (!m_axis_tvalid && t < 100) begin @(negedge clk); t++; end
    check("midrun_valid_seen", int'(m_axis_tvalid), 1);
    @(posedge clk);
    #1;
    arstn = 1'b0;
    @(posedge clk);
    #1;
    check("midrun_rst_m_tvalid", int'(m_axis_tvalid), 0);
    check("midrun_rst_s_tready", int'(s_axis_tready), 0);
    check("midrun_rst_m_tdata", int'(m_axis_tdata), 0);
    pushed_total = pushed_total - expq.size();
    expq.delete();
    model_clear();
    arstn = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_s_tready", int'(s_axis_tready), 1);
    send(8'h41);
    drain();

    check("total_packets", rx_total, pushed_total);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
